comparator: RTL and testbench



---
 rtl/comparator_pkg.sv | 32 +++
 rtl/comparator_core.sv | 43 ++++
 rtl/comparator.sv | 69 ++++++
 tb/tb_comparator.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types for the registered magnitude comparator.
// Optional signed compare is enabled with COMPARATOR_SIGNED_EN.
package comparator_pkg;

    localparam int unsigned CMP_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        CMP_LT = 2'd0,
        CMP_EQ = 2'd1,
        CMP_GT = 2'd2
    } cmp_result_e;

    typedef struct packed {
        logic equal;
        logic gt;
        logic lt;
    } cmp_flags_t;

    // The unused encoding 2'b11 decodes to all-zero flags rather than X.
    function automatic cmp_flags_t cmp_decode(input cmp_result_e res);
        cmp_flags_t flags;
        flags = '0;
        unique case (res)
            CMP_LT:  flags.lt    = 1'b1;
            CMP_EQ:  flags.equal = 1'b1;
            CMP_GT:  flags.gt    = 1'b1;
            default: flags       = '0;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/comparator_core.sv
// Combinational magnitude compare of a against b.
// With COMPARATOR_SIGNED_EN an is_signed input selects two's complement compare.
module comparator_core
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef COMPARATOR_SIGNED_EN
    input  logic             is_signed,
`endif
    output cmp_result_e      result
);

    logic sign_a;
    logic sign_b;

    // One extra bit carries the sign (or zero) so a single signed compare covers both modes.
`ifdef COMPARATOR_SIGNED_EN
    assign sign_a = is_signed & a[WIDTH-1];
    assign sign_b = is_signed & b[WIDTH-1];
`else
    assign sign_a = 1'b0;
    assign sign_b = 1'b0;
`endif

    logic signed [WIDTH:0] ext_a;
    logic signed [WIDTH:0] ext_b;

    assign ext_a = $signed({sign_a, a});
    assign ext_b = $signed({sign_b, b});

    always_comb begin
        result = CMP_EQ;
        if (ext_a < ext_b) begin
            result = CMP_LT;
        end else if (ext_a > ext_b) begin
            result = CMP_GT;
        end
    end

endmodule

// File: rtl/comparator.sv
// Registered comparator: one-cycle latency, one-hot flags held while idle.
// Build with COMPARATOR_SIGNED_EN to add the is_signed input.
module comparator
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef COMPARATOR_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             out_valid,
    output logic             equal,
    output logic             gt,
    output logic             lt
);

    cmp_result_e result_d;
    cmp_result_e result_q;
    logic        out_valid_q;
    logic        seen_q;
    cmp_flags_t  flags;

    comparator_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a         (a),
        .b         (b),
`ifdef COMPARATOR_SIGNED_EN
        .is_signed (is_signed),
`endif
        .result    (result_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            seen_q      <= 1'b0;
            result_q    <= CMP_EQ;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                result_q <= result_d;
                seen_q   <= 1'b1;
            end
        end
    end

    // Flags stay low until the first sample after reset has been captured.
    always_comb begin
        flags = '0;
        if (seen_q) begin
            flags = cmp_decode(result_q);
        end
    end

    assign out_valid = out_valid_q;
    assign equal     = flags.equal;
    assign gt        = flags.gt;
    assign lt        = flags.lt;

    a_flags_onehot0 : assert property (@(posedge clk) $onehot0({equal, gt, lt}));
    a_flags_onehot  : assert property (@(posedge clk) seen_q |-> $onehot({equal, gt, lt}));

endmodule

// File: tb/tb_comparator.sv
// Directed self-checking bench for comparator (WIDTH=3), both build variants.
module tb_comparator;

    localparam int unsigned WIDTH = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef COMPARATOR_SIGNED_EN
    logic             is_signed;
`endif
    logic             out_valid;
    logic             equal;
    logic             gt;
    logic             lt;

    int checks;
    int failures;

    comparator #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
`ifdef COMPARATOR_SIGNED_EN
        .is_signed (is_signed),
`endif
        .out_valid (out_valid),
        .equal     (equal),
        .gt        (gt),
        .lt        (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed/expected are packed as {out_valid, equal, gt, lt}.
    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got v/eq/gt/lt=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        in_valid = v;
        a        = av;
        b        = bv;
    endtask

    function automatic logic [3:0] outs();
        return {out_valid, equal, gt, lt};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b1, 3'd3, 3'd1);
`ifdef COMPARATOR_SIGNED_EN
        is_signed = 1'b0;
`endif

        // Reset held two cycles with a live sample: nothing gets through.
        step();
        check("reset_c1", outs(), 4'b0000);
        step();
        check("reset_c2", outs(), 4'b0000);
        rst_n = 1'b1;
        step();
        check("post_reset_first", outs(), 4'b1010);

        // Exhaustive sweep, one pair per cycle.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                logic [3:0] exp;
                drive(1'b1, WIDTH'(i), WIDTH'(j));
                exp = {1'b1, i == j, i > j, i < j};
                step();
                check($sformatf("sweep_%0d_%0d", i, j), outs(), exp);
            end
        end

        // Named examples with hand-computed results.
        drive(1'b1, 3'd5, 3'd5); step(); check("ex_5_5_eq", outs(), 4'b1100);
        drive(1'b1, 3'd7, 3'd0); step(); check("ex_7_0_gt", outs(), 4'b1010);
        drive(1'b1, 3'd0, 3'd7); step(); check("ex_0_7_lt", outs(), 4'b1001);

        // Idle hold: flags keep last result, out_valid drops.
        drive(1'b1, 3'd2, 3'd6); step(); check("idle_send", outs(), 4'b1001);
        drive(1'b0, 3'd7, 3'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("idle_hold_%0d", k), outs(), 4'b0001);
        end

        // Back-to-back samples.
        drive(1'b1, 3'd4, 3'd4); step(); check("b2b_eq", outs(), 4'b1100);
        drive(1'b1, 3'd6, 3'd1); step(); check("b2b_gt", outs(), 4'b1010);
        drive(1'b1, 3'd1, 3'd6); step(); check("b2b_lt", outs(), 4'b1001);

        // Reset on the same edge as a sample: result dropped, flags cleared.
        drive(1'b1, 3'd6, 3'd2);
        rst_n = 1'b0;
        step();
        check("midreset_clear", outs(), 4'b0000);
        rst_n = 1'b1;
        drive(1'b0, 3'd6, 3'd2);
        step();
        check("midreset_no_pulse", outs(), 4'b0000);
        step();
        check("midreset_idle", outs(), 4'b0000);

`ifdef COMPARATOR_SIGNED_EN
        is_signed = 1'b1;
        drive(1'b1, 3'b111, 3'b001); step(); check("signed_m1_p1", outs(), 4'b1001);
        is_signed = 1'b0;
        drive(1'b1, 3'b111, 3'b001); step(); check("unsigned_7_1", outs(), 4'b1010);
        is_signed = 1'b1;
        drive(1'b1, 3'b100, 3'b011); step(); check("signed_m4_p3", outs(), 4'b1001);
        drive(1'b1, 3'b110, 3'b110); step(); check("signed_eq", outs(), 4'b1100);
        drive(1'b1, 3'b010, 3'b101); step(); check("signed_p2_m3", outs(), 4'b1010);
`endif

        drive(1'b0, 3'd0, 3'd0);
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
